// File: rtl/hex_display_driver.sv
// hex_display_driver: registers a 32-bit word onto eight active-low seven-segment digits with
// leading-zero blanking, changed-digit blinking and an optional hold (enabled by HEXDRV_FREEZE_EN).
module hex_display_driver #(
  parameter int unsigned BLINK_CYCLES  = 25000000,
  parameter int unsigned FLASH_TOGGLES = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] HexDisplay32Bits,
  input  logic [4:0]  Display_Select,
  input  logic        Freeze,
  input  logic        Blank_Leading,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        Display_Changed,
  output logic        Frozen
);

  localparam int unsigned BC_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned TC_W = $clog2(FLASH_TOGGLES + 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, FLASH, FROZEN} state_t;

  state_t            state, state_next;
  logic [31:0]       shown, shown_next;
  logic [4:0]        prev_select, prev_select_next;
  logic [7:0]        mask, mask_next;
  logic              phase, phase_next;
  logic [BC_W-1:0]   blink_count, blink_next;
  logic [TC_W-1:0]   toggle_count, toggle_next;
  logic              changed_next;
  logic [7:0][6:0]   hex_q, hex_next;
  logic [7:0]        diff;
  logic              sel_same;
  logic              freeze_edge;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

`ifdef HEXDRV_FREEZE_EN
  logic freeze_q;

  // Freeze level history for rising-edge detection
  always_ff @(posedge Clock) begin
    if (Reset) freeze_q <= 1'b0;
    else       freeze_q <= Freeze;
  end

  assign freeze_edge = Freeze & ~freeze_q;
`else
  logic unused_freeze;
  assign unused_freeze = Freeze;
  assign freeze_edge   = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= IDLE;
      shown           <= '0;
      prev_select     <= '0;
      mask            <= '0;
      phase           <= 1'b0;
      blink_count     <= '0;
      toggle_count    <= '0;
      hex_q           <= {8{SEG_BLANK}};
      Display_Changed <= 1'b0;
      Frozen          <= 1'b0;
    end else begin
      state           <= state_next;
      shown           <= shown_next;
      prev_select     <= prev_select_next;
      mask            <= mask_next;
      phase           <= phase_next;
      blink_count     <= blink_next;
      toggle_count    <= toggle_next;
      hex_q           <= hex_next;
      Display_Changed <= changed_next;
      Frozen          <= (state_next == FROZEN);
    end
  end

  // Next-state: value/view change detection, blink timing, hold
  always_comb begin
    state_next       = state;
    shown_next       = shown;
    prev_select_next = prev_select;
    mask_next        = mask;
    phase_next       = phase;
    blink_next       = blink_count;
    toggle_next      = toggle_count;
    changed_next     = 1'b0;
    diff             = '0;
    for (int n = 0; n < 8; n++) begin
      diff[n] = |(HexDisplay32Bits[4*n +: 4] ^ shown[4*n +: 4]);
    end
    sel_same = (Display_Select == prev_select);

    case (state)
      IDLE, FLASH: begin
        shown_next       = HexDisplay32Bits;
        prev_select_next = Display_Select;
        if (freeze_edge) begin
          state_next  = FROZEN;
          mask_next   = '0;
          phase_next  = 1'b0;
          blink_next  = '0;
          toggle_next = '0;
        end else if (!sel_same) begin
          state_next  = IDLE;
          mask_next   = '0;
          phase_next  = 1'b0;
          blink_next  = '0;
          toggle_next = '0;
        end else if (|diff) begin
          // A flash already running accumulates the newly changed digits
          state_next   = FLASH;
          mask_next    = (state == FLASH) ? (mask | diff) : diff;
          phase_next   = 1'b0;
          blink_next   = '0;
          toggle_next  = '0;
          changed_next = 1'b1;
        end else if (state == FLASH) begin
          if (blink_count == BC_W'(BLINK_CYCLES - 1)) begin
            blink_next = '0;
            if (toggle_count == TC_W'(FLASH_TOGGLES - 1)) begin
              state_next  = IDLE;
              mask_next   = '0;
              phase_next  = 1'b0;
              toggle_next = '0;
            end else begin
              phase_next  = ~phase;
              toggle_next = toggle_count + TC_W'(1);
            end
          end else begin
            blink_next = blink_count + BC_W'(1);
          end
        end
      end
      FROZEN: begin
        if (freeze_edge) begin
          state_next       = IDLE;
          shown_next       = HexDisplay32Bits;
          prev_select_next = Display_Select;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Digit decode with leading-zero and blink blanking
  always_comb begin
    hex_next = {8{SEG_BLANK}};
    for (int n = 0; n < 8; n++) begin
      if ((Blank_Leading && (n != 0) && ((shown >> (4 * n)) == 32'd0)) || (phase && mask[n]))
        hex_next[n] = SEG_BLANK;
      else
        hex_next[n] = seg7(shown[4*n +: 4]);
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule
